instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Front-end fetch stage feeding the cpu decode/execute core. Owns the fetch PC and issues
//   word reads to a 1-cycle-latency instruction memory. Buffers returned words with their PCs
//   in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
//   Accepts branch/jump redirects from execute: flushes the FIFO and drops the in-flight read.
// PARAMETERS
//   ADDR_W    16       width of PC / imem address (word addressed, +1 per instruction)
//   DATA_W    16       instruction width
//   DEPTH     2        prefetch FIFO entries; must be >= 2 for 1 instr/cycle throughput
//   RESET_PC  16'h0000 fetch PC loaded on reset
// PORTS
//   clk          in   1           system clock, all state updates on rising edge
//   rst          in   1           synchronous reset, active-high
//   imem_req     out  1           read strobe; data returns on imem_rdata in the next cycle
//   imem_addr    out  ADDR_W      read address (= fetch_pc while imem_req=1)
//   imem_rdata   in   DATA_W      read data, valid exactly one cycle after imem_req=1
//   redirect     in   1           branch taken / jump: restart fetch at redirect_pc
//   redirect_pc  in   ADDR_W      target PC
//   ir_valid     out  1           head FIFO entry presented to core
//   ir_ready     in   1           core accepts ir this cycle
//   ir           out  DATA_W      instruction word (0 when ir_valid=0)
//   ir_pc        out  ADDR_W      PC of ir (0 when ir_valid=0)
//   buf_count    out  clog2(DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//   - Reset (rst=1 at edge): fetch_pc<=RESET_PC, FIFO empty, inflight<=0, discard<=0.
//     Outputs in/after reset cycle: imem_req=0, ir_valid=0, ir=0, ir_pc=0, buf_count=0.
//   - pop = ir_valid & ir_ready. issue = !rst & !redirect & (count + inflight - pop < DEPTH).
//     imem_req=issue, imem_addr=fetch_pc. On issue: fetch_pc<=fetch_pc+1 (wraps FFFF->0000),
//     inflight<=1, inflight_pc<=fetch_pc. Else inflight<=0.
//   - Response: when inflight=1 and discard=0, push {imem_rdata, inflight_pc} at the edge.
//   - Latency: first imem_req in cycle N -> ir_valid=1 in cycle N+2. Steady state with
//     ir_ready=1: one instruction per cycle, PCs consecutive.
//   - Push+pop same edge: count unchanged, order preserved. Pop never on empty; push never
//     exceeds DEPTH (guaranteed by issue rule; assert in sim).
//   - Backpressure (ir_ready=0): FIFO fills to DEPTH, imem_req drops to 0, ir/ir_pc stable.
//   - Redirect cycle: ir_valid forced 0 (no handshake occurs), imem_req=0. At the edge:
//     FIFO flushed (count<=0), fetch_pc<=redirect_pc, discard<=inflight so the response
//     arriving next cycle is dropped. Next cycle issues redirect_pc. Target ir_valid at
//     redirect cycle +3. Back-to-back redirects: last one wins.
//   - rst mid-operation: identical to reset; pending response ignored.
// STRUCTURE
//   - Shared header cpu_defs.vh: ADDR_W, DATA_W, RESET_PC, NOP encoding (16'h0000).
//   - One sub-module: fetch_fifo (sync FIFO, DEPTH x (DATA_W+ADDR_W), push/pop/flush,
//     count, head out; wrap-around rd/wr pointers). Top holds PC, inflight, discard logic.
// TESTING  (imem model: mem[a] = 16'hA000 | a, 1-cycle read latency)
//   1 Reset 2 cycles, release, ir_ready=1 -> req addr 0,1,2..; ir_valid 2 cycles after
//     first req; ir/ir_pc = A000/0000, A001/0001, A002/0002 one per cycle.
//   2 ir_ready=0 for 6 cycles -> buf_count=2, imem_req=0, ir held A000; ready=1 -> no
//     loss/duplication, sequence continues A001, A002.
//   3 redirect=1, redirect_pc=0040 during streaming -> ir_valid=0 that cycle, no word from
//     old path after it; next ir = A040/0040 three cycles later, then A041.
//   4 RESET_PC=FFFE -> ir_pc FFFE, FFFF, 0000, 0001 (wrap).
//   5 rst asserted with FIFO full and read in flight -> next cycle ir_valid=0, buf_count=0;
//     after release stream restarts at RESET_PC.
//   6 Random ir_ready + random redirects 10k cycles -> scoreboard: ir_pc sequence matches
//     reference PC model, ir == A000|ir_pc, buf_count never > DEPTH.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch front-end: default widths, reset PC, NOP encoding
// and the FIFO operation decode used by the prefetch buffer.
package instr_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] NOP_INSTR    = 16'h0000;

    typedef enum logic [1:0] {
        FIFO_IDLE,
        FIFO_PUSH,
        FIFO_POP,
        FIFO_BOTH
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        fifo_op_e op;
        case ({push, pop})
            2'b10:   op = FIFO_PUSH;
            2'b01:   op = FIFO_POP;
            2'b11:   op = FIFO_BOTH;
            default: op = FIFO_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the decode/execute core.
// master = fetch unit side, slave = memory/core side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic [CNT_W-1:0]  buf_count;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc, buf_count,
        input  imem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc, buf_count,
        output imem_rdata, redirect, redirect_pc, ir_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {instr, pc}, wrap-around pointers, flush has priority
// over push/pop so a redirect drops anything arriving in the same cycle.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_clear;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_clear = rst | i_flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case (fifo_op(i_push, i_pop))
                FIFO_PUSH: r_count <= r_count + 1'b1;
                FIFO_POP:  r_count <= r_count - 1'b1;
                default:   r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!w_clear && i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // The issue rule upstream guarantees these never fire.
    always_ff @(posedge clk) begin
        if (!w_clear) begin
            assert (!(i_pop && r_count == '0));
            assert (!(i_push && !i_pop && r_count == CNT_W'(DEPTH)));
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads, buffers returned
// words with their PCs and hands them to the core over valid/ready; redirects restart fetch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WIDE_W = CNT_W + 1;

    logic [ADDR_W-1:0]        r_fetch_pc;
    logic                     r_inflight;
    logic [ADDR_W-1:0]        r_inflight_pc;
    logic                     r_discard;

    logic [CNT_W-1:0]         w_count;
    logic [DATA_W+ADDR_W-1:0] w_head;
    logic [DATA_W-1:0]        w_head_data;
    logic [ADDR_W-1:0]        w_head_pc;
    logic                     w_ir_valid;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;
    logic [WIDE_W-1:0]        w_pending;

    assign w_head_data = w_head[ADDR_W +: DATA_W];
    assign w_head_pc   = w_head[ADDR_W-1:0];

    // Nothing is presented during reset or a redirect, so no handshake can happen then.
    assign w_ir_valid = !rst && !bus.redirect && (w_count != '0);
    assign w_pop      = w_ir_valid && bus.ir_ready;

    // Slots committed after this edge: buffered + in flight - leaving now.
    assign w_pending = WIDE_W'(w_count) + WIDE_W'(r_inflight) - WIDE_W'(w_pop);
    assign w_issue   = !rst && !bus.redirect && (w_pending < WIDE_W'(DEPTH));
    assign w_push    = r_inflight && !r_discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_discard     <= 1'b0;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_discard  <= r_inflight;
        end else begin
            r_discard  <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_wdata ({bus.imem_rdata, r_inflight_pc}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.ir_valid  = w_ir_valid;
    assign bus.ir        = w_ir_valid ? w_head_data : DATA_W'(NOP_INSTR);
    assign bus.ir_pc     = w_ir_valid ? w_head_pc : '0;
    assign bus.buf_count = rst ? '0 : w_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector table plus hand sequences and a randomized scoreboard for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic clk;
    logic rst0;
    logic rst1;
    int   errors;
    int   checks;

    instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) bus0 ();
    instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) bus1 ();

    instr_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    instr_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'hFFFE)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem model: mem[a] = A000 | a, one cycle read latency.
    always @(posedge clk) begin
        bus0.imem_rdata <= bus0.imem_req ? (16'hA000 | bus0.imem_addr) : 16'hDEAD;
        bus1.imem_rdata <= bus1.imem_req ? (16'hA000 | bus1.imem_addr) : 16'hDEAD;
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic rdy, input logic rd,
                               input logic [15:0] rpc, input logic req,
                               input logic [15:0] addr, input logic valid,
                               input logic [15:0] pc, input int cnt);
        vec_t t;
        t.rst = r; t.ready = rdy; t.redir = rd; t.rpc = rpc;
        t.req = req; t.addr = addr; t.valid = valid; t.pc = pc; t.cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare one DUT's outputs against an expected cycle; ir follows from the imem model.
    task automatic expect_cycle(input string tag, input bit sel, input logic req,
                                input logic [15:0] addr, input logic valid,
                                input logic [15:0] pc, input int cnt);
        logic        a_req, a_valid;
        logic [15:0] a_addr, a_ir, a_pc, e_ir, e_pc;
        int          a_cnt;
        a_req   = sel ? bus1.imem_req  : bus0.imem_req;
        a_addr  = sel ? bus1.imem_addr : bus0.imem_addr;
        a_valid = sel ? bus1.ir_valid  : bus0.ir_valid;
        a_ir    = sel ? bus1.ir        : bus0.ir;
        a_pc    = sel ? bus1.ir_pc     : bus0.ir_pc;
        a_cnt   = sel ? int'(bus1.buf_count) : int'(bus0.buf_count);
        e_ir    = valid ? (16'hA000 | pc) : 16'h0000;
        e_pc    = valid ? pc : 16'h0000;
        check({tag, ".imem_req"}, int'(a_req), int'(req));
        if (req) check({tag, ".imem_addr"}, int'(a_addr), int'(addr));
        check({tag, ".ir_valid"}, int'(a_valid), int'(valid));
        check({tag, ".ir"}, int'(a_ir), int'(e_ir));
        check({tag, ".ir_pc"}, int'(a_pc), int'(e_pc));
        check({tag, ".buf_count"}, a_cnt, cnt);
    endtask

    task automatic drive0(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc);
        rst0             = r;
        bus0.ir_ready    = rdy;
        bus0.redirect    = rd;
        bus0.redirect_pc = rpc;
    endtask

    initial begin
        logic [15:0] exp_pc;
        int          pops;
        errors = 0;
        checks = 0;
        rst1             = 1'b1;
        bus1.ir_ready    = 1'b1;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = 16'h0000;

        // rst rdy rdr rpc | req addr | valid pc | cnt
        vecs.push_back(v(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(v(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 1));
        vecs.push_back(v(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 2));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003, 2));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0007, 1, 16'h0005, 1));
        vecs.push_back(v(0, 1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0043, 1, 16'h0041, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0044, 1, 16'h0042, 1));
        vecs.push_back(v(0, 1, 1, 16'h0100, 0, 16'h0000, 0, 16'h0000, 1));
        vecs.push_back(v(0, 1, 1, 16'h0200, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0201, 0, 16'h0000, 0));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0202, 1, 16'h0200, 1));
        vecs.push_back(v(0, 1, 0, 16'h0000, 1, 16'h0203, 1, 16'h0201, 1));

        foreach (vecs[i]) begin
            drive0(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            #1;
            expect_cycle($sformatf("vec%0d", i), 1'b0, vecs[i].req, vecs[i].addr,
                         vecs[i].valid, vecs[i].pc, vecs[i].cnt);
            next_cycle();
        end

        // Reset with FIFO full: stall until two entries are buffered.
        drive0(0, 0, 0, 16'h0000);
        next_cycle();
        next_cycle();
        #1;
        expect_cycle("full.stall", 1'b0, 0, 16'h0000, 1, 16'h0202, 2);
        drive0(1, 1, 0, 16'h0000);
        #1;
        expect_cycle("full.rst", 1'b0, 0, 16'h0000, 0, 16'h0000, 0);
        next_cycle();
        drive0(0, 1, 0, 16'h0000);
        #1;
        expect_cycle("full.rel0", 1'b0, 1, 16'h0000, 0, 16'h0000, 0);
        next_cycle();
        #1;
        expect_cycle("full.rel1", 1'b0, 1, 16'h0001, 0, 16'h0000, 0);
        next_cycle();
        #1;
        expect_cycle("full.rel2", 1'b0, 1, 16'h0002, 1, 16'h0000, 1);
        next_cycle();

        // Reset while streaming with a read in flight: that response must be ignored.
        drive0(1, 1, 0, 16'h0000);
        #1;
        expect_cycle("infl.rst", 1'b0, 0, 16'h0000, 0, 16'h0000, 0);
        next_cycle();
        drive0(0, 1, 0, 16'h0000);
        #1;
        expect_cycle("infl.rel0", 1'b0, 1, 16'h0000, 0, 16'h0000, 0);
        next_cycle();
        #1;
        expect_cycle("infl.rel1", 1'b0, 1, 16'h0001, 0, 16'h0000, 0);
        next_cycle();
        #1;
        expect_cycle("infl.rel2", 1'b0, 1, 16'h0002, 1, 16'h0000, 1);
        next_cycle();

        // PC wrap from RESET_PC = FFFE on the second instance.
        rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, p;
            a = 16'hFFFE + 16'(i);
            p = 16'hFFFE + 16'(i) - 16'd2;
            #1;
            expect_cycle($sformatf("wrap%0d", i), 1'b1, 1, a, (i >= 2), p, (i >= 2) ? 1 : 0);
            next_cycle();
        end

        // Random ready/redirect against a reference PC model.
        drive0(1, 1, 0, 16'h0000);
        next_cycle();
        exp_pc = 16'h0000;
        pops   = 0;
        for (int c = 0; c < 10000; c++) begin
            drive0(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                   16'($urandom_range(0, 65535)));
            #1;
            check("rand.buf_count_le_depth", int'(bus0.buf_count <= 2), 1);
            if (bus0.redirect) begin
                check("rand.redirect_valid", int'(bus0.ir_valid), 0);
                check("rand.redirect_req", int'(bus0.imem_req), 0);
                exp_pc = bus0.redirect_pc;
            end else if (bus0.ir_valid && bus0.ir_ready) begin
                check("rand.ir_pc", int'(bus0.ir_pc), int'(exp_pc));
                check("rand.ir", int'(bus0.ir), int'(16'hA000 | exp_pc));
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            next_cycle();
        end
        check("rand.progress", int'(pops > 2000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
